// File: rtl/eight_bit_one_to_two_demux_router_module_pkg.sv
// rtl/eight_bit_one_to_two_demux_router_module_pkg.sv - shared constants and occupancy encoding for the 1:2 byte router
package eight_bit_one_to_two_demux_router_module_pkg;

   localparam int          WIDTH       = 8;
   localparam int          COUNT_WIDTH = 8;
   localparam logic [1:0]  DEPTH       = 2'd2;

   // Encoding doubles as the number of bytes held, so it compares directly against DEPTH.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_state_t;

   function automatic logic [1:0] occ_level(input occ_state_t s);
      return 2'(s);
   endfunction

endpackage

// File: rtl/eight_bit_one_to_two_demux_router_module_if.sv
// rtl/eight_bit_one_to_two_demux_router_module_if.sv - producer and two consumer handshakes of the 1:2 byte router
interface eight_bit_one_to_two_demux_router_module_if;
   import eight_bit_one_to_two_demux_router_module_pkg::*;

   logic                   in_valid;
   logic                   in_sel;
   logic [WIDTH-1:0]       in_data;
   logic                   in_ready;

   logic                   out0_valid;
   logic [WIDTH-1:0]       out0_data;
   logic                   out0_ready;
   logic [COUNT_WIDTH-1:0] out0_count;

   logic                   out1_valid;
   logic [WIDTH-1:0]       out1_data;
   logic                   out1_ready;
   logic [COUNT_WIDTH-1:0] out1_count;

   // slave is the router's view; master is the producer/consumer environment.
   modport slave (
      input  in_valid, in_sel, in_data, out0_ready, out1_ready,
      output in_ready, out0_valid, out0_data, out0_count,
             out1_valid, out1_data, out1_count
   );

   modport master (
      output in_valid, in_sel, in_data, out0_ready, out1_ready,
      input  in_ready, out0_valid, out0_data, out0_count,
             out1_valid, out1_data, out1_count
   );

endinterface

// File: rtl/eight_bit_one_to_two_demux_router_module_out_buffer.sv
// rtl/eight_bit_one_to_two_demux_router_module_out_buffer.sv - per-output 2-entry FIFO with occupancy FSM and delivered-byte counter
module demux_out_buffer_module
   import eight_bit_one_to_two_demux_router_module_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   output logic                   can_accept,
   output logic                   valid,
   output logic [WIDTH-1:0]       data,
   input  logic                   ready,
   output logic [COUNT_WIDTH-1:0] count
);

   occ_state_t             state_q, state_d;
   logic [WIDTH-1:0]       head_q, head_d;
   logic [WIDTH-1:0]       tail_q, tail_d;
   logic [COUNT_WIDTH-1:0] count_q;
   logic                   pop;

   assign valid      = (state_q != EMPTY);
   assign can_accept = (occ_level(state_q) < DEPTH);
   assign data       = head_q;
   assign count      = count_q;
   assign pop        = valid && ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         if (pop) begin
            count_q <= count_q + 1'b1;
         end
      end
   end

   // The head register always feeds the output; tail only holds the second byte.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               state_d = ONE;
               head_d  = push_data;
            end
         end
         ONE: begin
            if (push && pop) begin
               head_d = push_data;
            end else if (push) begin
               state_d = TWO;
               tail_d  = push_data;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               state_d = ONE;
               head_d  = tail_q;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

endmodule

// File: rtl/eight_bit_one_to_two_demux_router_module.sv
// rtl/eight_bit_one_to_two_demux_router_module.sv - buffered 8-bit 1:2 demux steering each byte by in_sel
module eight_bit_one_to_two_demux_router_module
   import eight_bit_one_to_two_demux_router_module_pkg::*;
(
   input  logic                                   clk,
   input  logic                                   reset_n,
   eight_bit_one_to_two_demux_router_module_if.slave bus
);

   logic [1:0] can_accept;
   logic       push0;
   logic       push1;

   // Readiness follows only the addressed buffer, so a stalled consumer never blocks the other.
   assign bus.in_ready = reset_n && can_accept[bus.in_sel];
   assign push0        = bus.in_valid && bus.in_ready && !bus.in_sel;
   assign push1        = bus.in_valid && bus.in_ready &&  bus.in_sel;

   demux_out_buffer_module u_out0 (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (push0),
      .push_data  (bus.in_data),
      .can_accept (can_accept[0]),
      .valid      (bus.out0_valid),
      .data       (bus.out0_data),
      .ready      (bus.out0_ready),
      .count      (bus.out0_count)
   );

   demux_out_buffer_module u_out1 (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (push1),
      .push_data  (bus.in_data),
      .can_accept (can_accept[1]),
      .valid      (bus.out1_valid),
      .data       (bus.out1_data),
      .ready      (bus.out1_ready),
      .count      (bus.out1_count)
   );

endmodule

// File: tb/tb_eight_bit_one_to_two_demux_router_module.sv
// tb/tb_eight_bit_one_to_two_demux_router_module.sv - directed self-checking bench for the 1:2 byte router
module tb_eight_bit_one_to_two_demux_router_module;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   eight_bit_one_to_two_demux_router_module_if bus ();

   eight_bit_one_to_two_demux_router_module dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [7:0] d);
      bus.in_valid = v;
      bus.in_sel   = s;
      bus.in_data  = d;
      #1;
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      reset_n         = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_sel      = 1'b0;
      bus.in_data     = 8'h00;
      bus.out0_ready  = 1'b0;
      bus.out1_ready  = 1'b0;

      tick();
      tick();
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_out0_valid", bus.out0_valid, 1'b0);
      chk("rst_out1_valid", bus.out1_valid, 1'b0);
      chk("rst_out0_data", bus.out0_data, 8'h00);
      chk("rst_out1_data", bus.out1_data, 8'h00);
      chk("rst_out0_count", bus.out0_count, 8'h00);
      chk("rst_out1_count", bus.out1_count, 8'h00);

      reset_n = 1'b1;
      #1;
      chk("post_rst_in_ready", bus.in_ready, 1'b1);

      // Single route to out0
      bus.out0_ready = 1'b1;
      drive(1'b1, 1'b0, 8'h3C);
      chk("single_in_ready", bus.in_ready, 1'b1);
      tick();
      drive(1'b0, 1'b0, 8'h00);
      chk("single_out0_valid", bus.out0_valid, 1'b1);
      chk("single_out0_data", bus.out0_data, 8'h3C);
      chk("single_out1_valid", bus.out1_valid, 1'b0);
      chk("single_count_before_pop", bus.out0_count, 8'h00);
      tick();
      chk("single_out0_count", bus.out0_count, 8'h01);
      chk("single_out0_empty", bus.out0_valid, 1'b0);

      // Fill out1 while its consumer stalls
      bus.out1_ready = 1'b0;
      drive(1'b1, 1'b1, 8'h11);
      chk("bp_ready_11", bus.in_ready, 1'b1);
      tick();
      drive(1'b1, 1'b1, 8'h22);
      chk("bp_ready_22", bus.in_ready, 1'b1);
      tick();

      // Isolation: out0 still accepts while out1 is full
      drive(1'b1, 1'b0, 8'hA5);
      chk("iso_in_ready", bus.in_ready, 1'b1);
      tick();
      drive(1'b0, 1'b0, 8'h00);
      chk("iso_out0_valid", bus.out0_valid, 1'b1);
      chk("iso_out0_data", bus.out0_data, 8'hA5);
      tick();
      chk("iso_out0_count", bus.out0_count, 8'h02);
      chk("iso_out1_valid", bus.out1_valid, 1'b1);
      chk("iso_out1_head", bus.out1_data, 8'h11);

      // Third byte to full out1 is refused
      drive(1'b1, 1'b1, 8'h33);
      chk("bp_ready_33", bus.in_ready, 1'b0);
      tick();
      chk("bp_ready_33_hold", bus.in_ready, 1'b0);
      chk("bp_head_hold", bus.out1_data, 8'h11);
      chk("bp_count_hold", bus.out1_count, 8'h00);

      bus.out1_ready = 1'b1;
      tick();
      chk("bp_head_22", bus.out1_data, 8'h22);
      chk("bp_count_1", bus.out1_count, 8'h01);
      chk("bp_ready_after_pop", bus.in_ready, 1'b1);
      tick();
      drive(1'b0, 1'b0, 8'h00);
      chk("bp_head_33", bus.out1_data, 8'h33);
      chk("bp_count_2", bus.out1_count, 8'h02);
      chk("bp_valid_33", bus.out1_valid, 1'b1);
      tick();
      chk("bp_count_3", bus.out1_count, 8'h03);
      chk("bp_out1_empty", bus.out1_valid, 1'b0);

      // Simultaneous push/pop streaming on out0
      bus.out0_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, 1'b0, 8'(i));
         chk("stream_in_ready", bus.in_ready, 1'b1);
         tick();
         chk("stream_valid", bus.out0_valid, 1'b1);
         chk("stream_data", bus.out0_data, 32'(i));
      end
      drive(1'b0, 1'b0, 8'h00);
      tick();
      chk("stream_count", bus.out0_count, 8'h12);
      chk("stream_out0_empty", bus.out0_valid, 1'b0);
      chk("stream_out1_count", bus.out1_count, 8'h03);

      // Both buffers to TWO, then reset mid-stream
      bus.out0_ready = 1'b0;
      bus.out1_ready = 1'b0;
      drive(1'b1, 1'b0, 8'h5A);
      tick();
      drive(1'b1, 1'b0, 8'h6B);
      tick();
      drive(1'b1, 1'b1, 8'h7C);
      tick();
      drive(1'b1, 1'b1, 8'h8D);
      tick();
      drive(1'b1, 1'b0, 8'h00);
      chk("full_ready0", bus.in_ready, 1'b0);
      drive(1'b1, 1'b1, 8'h00);
      chk("full_ready1", bus.in_ready, 1'b0);
      chk("full_out1_head", bus.out1_data, 8'h7C);
      drive(1'b0, 1'b0, 8'h00);

      reset_n = 1'b0;
      #1;
      chk("mid_rst_out0_valid", bus.out0_valid, 1'b0);
      chk("mid_rst_out1_valid", bus.out1_valid, 1'b0);
      chk("mid_rst_out0_count", bus.out0_count, 8'h00);
      chk("mid_rst_out1_count", bus.out1_count, 8'h00);
      chk("mid_rst_out1_data", bus.out1_data, 8'h00);
      chk("mid_rst_in_ready", bus.in_ready, 1'b0);
      tick();
      reset_n = 1'b1;
      #1;
      chk("mid_rst_release_ready", bus.in_ready, 1'b1);

      // 256 deliveries on out1 wrap its counter back to zero
      bus.out1_ready = 1'b1;
      for (int k = 0; k < 256; k++) begin
         drive(1'b1, 1'b1, 8'(k));
         tick();
         if (k == 0 || k == 128 || k == 255) begin
            chk("wrap_count_progress", bus.out1_count, 32'(k));
            chk("wrap_data", bus.out1_data, 32'(k));
         end
      end
      drive(1'b0, 1'b0, 8'h00);
      tick();
      chk("wrap_out1_count", bus.out1_count, 8'h00);
      chk("wrap_out1_empty", bus.out1_valid, 1'b0);
      chk("wrap_out0_count", bus.out0_count, 8'h00);
      chk("wrap_out0_valid", bus.out0_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
